// File: rtl/bist_pkg.sv
// Shared constants and FSM encoding for the BIST status controller.
package bist_pkg;

   localparam int         STATUS_W    = 16;
   localparam logic [3:0] ERR_TIMEOUT = 4'hF;
   localparam int         CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_READY = 2'd2,
      ST_SHIFT = 2'd3
   } bist_state_t;

endpackage

// File: rtl/bist_ctrl_if.sv
// TAP strobes and BIST engine handshake seen by the controller.
interface bist_ctrl_if #(
   parameter int STATUS_W = bist_pkg::STATUS_W
);

   logic                BIST_SEL;
   logic                RUN_BIST;
   logic                CAPTURE_DR;
   logic                SHIFT_DR;
   logic                UPDATE_DR;
   logic                BIST_DONE;
   logic [STATUS_W-1:0] BIST_STATUS;
   logic                BIST_START;
   logic                TDO;
   logic                BUSY;
   logic                TIMEOUT_ERR;

   modport master (
      output BIST_SEL, RUN_BIST, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
             BIST_DONE, BIST_STATUS,
      input  BIST_START, TDO, BUSY, TIMEOUT_ERR
   );

   modport slave (
      input  BIST_SEL, RUN_BIST, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
             BIST_DONE, BIST_STATUS,
      output BIST_START, TDO, BUSY, TIMEOUT_ERR
   );

endinterface

// File: rtl/bist_status_shifter.sv
// Status readout shift register: parallel load, LSB-first serial out, zero fill.
module bist_status_shifter
   import bist_pkg::*;
#(
   parameter int STATUS_W = bist_pkg::STATUS_W
) (
   input  logic                TCK,
   input  logic                TRST_N,
   input  logic                load,
   input  logic                shift,
   input  logic                clear,
   input  logic [STATUS_W-1:0] din,
   output logic                TDO
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STATUS_W - 1);

   logic [STATUS_W-1:0] sreg;
   logic [CNT_W-1:0]    bit_cnt;

   // Load wins over shift so a capture always restarts the readout at bit 0.
   always_ff @(posedge TCK) begin
      if (!TRST_N || clear) begin
         sreg    <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         sreg    <= din;
         bit_cnt <= '0;
      end else if (shift) begin
         sreg    <= {1'b0, sreg[STATUS_W-1:1]};
         bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
      end
   end

   assign TDO = sreg[0];

endmodule

// File: rtl/bist_ctrl.sv
// BIST run sequencer: starts the engine, waits for done or timeout, and holds the
// status word in a shadow register for serial readout through the TAP DR path.
module bist_ctrl
   import bist_pkg::*;
#(
   parameter int STATUS_W = bist_pkg::STATUS_W,
   parameter int TIMEOUT  = 1023
) (
   input  logic       TCK,
   input  logic       TRST_N,
   bist_ctrl_if.slave bus
);

   localparam int               TMR_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

   bist_state_t         state, state_nxt;
   logic [TMR_W-1:0]    timer;
   logic [STATUS_W-1:0] shadow;
   logic                bist_start_q;
   logic                timeout_err_q;

   logic go, done_hit, to_hit, cap_hit, shift_hit, sh_clear;

   function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
      return (v == TMR_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge TCK) begin
      if (!TRST_N) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (go) state_nxt = ST_RUN;
         ST_RUN:   if (done_hit || to_hit) state_nxt = ST_READY;
         ST_READY: begin
            if (go)           state_nxt = ST_RUN;
            else if (cap_hit) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: if (!bus.BIST_SEL || bus.UPDATE_DR) state_nxt = ST_READY;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Done is tested before the timer so a completion on the last cycle is not an error.
   always_comb begin
      go        = 1'b0;
      done_hit  = 1'b0;
      to_hit    = 1'b0;
      cap_hit   = 1'b0;
      shift_hit = 1'b0;
      sh_clear  = 1'b0;
      case (state)
         ST_IDLE: begin
            go      = bus.BIST_SEL & bus.RUN_BIST;
            cap_hit = bus.BIST_SEL & bus.CAPTURE_DR;
         end
         ST_RUN: begin
            done_hit = bus.BIST_DONE;
            to_hit   = !bus.BIST_DONE && (timer == TMR_MAX);
         end
         ST_READY: begin
            go      = bus.BIST_SEL & bus.RUN_BIST;
            cap_hit = bus.BIST_SEL & bus.CAPTURE_DR & ~go;
         end
         ST_SHIFT: begin
            if (!bus.BIST_SEL) begin
               sh_clear = 1'b1;
            end else begin
               cap_hit   = bus.CAPTURE_DR;
               shift_hit = bus.SHIFT_DR & ~bus.CAPTURE_DR;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (!TRST_N) begin
         timer         <= '0;
         shadow        <= '0;
         bist_start_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         bist_start_q <= go;
         if (go) begin
            timer         <= '0;
            timeout_err_q <= 1'b0;
         end else if (state == ST_RUN) begin
            timer <= sat_inc(timer);
         end
         if (done_hit) begin
            shadow <= bus.BIST_STATUS;
         end else if (to_hit) begin
            shadow        <= {bus.BIST_STATUS[STATUS_W-1:4], ERR_TIMEOUT};
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign bus.BIST_START  = bist_start_q;
   assign bus.BUSY        = (state == ST_RUN);
   assign bus.TIMEOUT_ERR = timeout_err_q;

   bist_status_shifter #(
      .STATUS_W (STATUS_W)
   ) u_shifter (
      .TCK    (TCK),
      .TRST_N (TRST_N),
      .load   (cap_hit),
      .shift  (shift_hit),
      .clear  (sh_clear),
      .din    (shadow),
      .TDO    (bus.TDO)
   );

endmodule

// File: doc/bist_ctrl.md
BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 Parameter STATUS_W, default 16, SHALL set the status word width.
REQ-002 Parameter TIMEOUT, default 1023, SHALL set the maximum TCK cycles spent waiting for BIST_DONE.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 TCK  in  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-005 TRST_N  in  1  SHALL be the synchronous active-low reset.
REQ-006 BIST_SEL  in  1  SHALL indicate the BIST instruction is loaded in the IR.
REQ-007 RUN_BIST  in  1  SHALL be a run request, sampled in Run-Test/Idle.
REQ-008 CAPTURE_DR, SHIFT_DR, UPDATE_DR  in  1 each  SHALL be the TAP DR-phase strobes.
REQ-009 BIST_DONE  in  1  SHALL be the engine completion flag.
REQ-010 BIST_STATUS  in  STATUS_W  SHALL be the engine status word: [input at error][expected][got][error code 3:0].
REQ-011 BIST_START  out  1  SHALL be a one-cycle engine start pulse.
REQ-012 TDO  out  1  SHALL be the serial status output, LSB first.
REQ-013 BUSY  out  1  SHALL be high while in RUN.
REQ-014 TIMEOUT_ERR  out  1  SHALL flag that the last run timed out.

Function
REQ-015 The FSM SHALL use the states IDLE, RUN, READY and SHIFT.
REQ-016 In IDLE or READY, BIST_SEL & RUN_BIST SHALL cause the next state RUN, a one-cycle BIST_START, a cleared timer and a cleared TIMEOUT_ERR.
REQ-017 In RUN, the timer SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-018 In RUN, RUN_BIST SHALL be ignored.
REQ-019 In RUN, BIST_DONE=1 SHALL latch BIST_STATUS into the shadow register and set the next state READY; BIST_DONE SHALL take priority over timeout on the same cycle.
REQ-020 In RUN, timer==TIMEOUT with BIST_DONE=0 SHALL latch BIST_STATUS with bits [3:0] forced to 4'hF, set TIMEOUT_ERR and set the next state READY.
REQ-021 In READY, BIST_SEL & CAPTURE_DR SHALL load the shift register from the shadow, clear the 4-bit bit counter and set the next state SHIFT.
REQ-022 TDO SHALL equal shift-register bit 0, flop-driven, so bit 0 is valid in the cycle after capture.
REQ-023 In SHIFT, each BIST_SEL & SHIFT_DR edge SHALL shift the register right, zero-fill the MSB and increment the counter.
REQ-024 After STATUS_W shifts the counter SHALL wrap to 0, and TDO SHALL stay 0 for any further shifts.
REQ-025 In SHIFT, UPDATE_DR SHALL return the FSM to READY with the shadow unchanged, so a repeat readout gives the same word.
REQ-026 If CAPTURE_DR and SHIFT_DR are high together, capture SHALL win, reload the register and restart the counter.
REQ-027 BIST_SEL deasserted in SHIFT SHALL return the FSM to READY and clear the shift register (TDO=0).
REQ-028 In IDLE, capture SHALL load an all-zero word, since the shadow resets to 0.

Reset
REQ-029 TRST_N=0 at a TCK edge SHALL force state IDLE, BIST_START=0, BUSY=0, TIMEOUT_ERR=0, TDO=0, and clear the timer, shadow, shift register and counter.
REQ-030 Reset during RUN or SHIFT SHALL abort the operation, with no BIST_START pulse generated on exit.

Structure
REQ-031 Package bist_pkg SHALL hold STATUS_W, ERR_TIMEOUT=4'hF and the FSM state encoding.
REQ-032 The shift register, bit counter and TDO SHALL be in sub-module bist_status_shifter; the FSM, timer and shadow SHALL be in bist_ctrl.

Verification
REQ-033 Normal run: RUN_BIST; BIST_DONE 5 cycles later with status 16'hA5C3 -> one BIST_START pulse, BUSY for 6 cycles, 16 shifts give TDO 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
REQ-034 Timeout with TIMEOUT=8 and no DONE -> READY after 9 RUN cycles, TIMEOUT_ERR=1, captured bits[3:0]=4'hF.
REQ-035 Over-shift: 20 shifts of 16'hFFFF -> 16 ones, then 4 zeros.
REQ-036 CAPTURE_DR and SHIFT_DR together mid-shift -> TDO restarts at bit 0.
REQ-037 TRST_N low during RUN and during SHIFT -> all outputs 0 the next cycle; a following capture yields 0.
REQ-038 RUN_BIST pulsed during RUN -> no second BIST_START; UPDATE_DR then re-capture -> identical word.
